// File: rtl/lpm_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : lpm_ram_burst_reader
// Brief    : Burst read initiator for an LPM RAM read port, returning words on
//            a valid/ready stream through a credit-limited skid FIFO.
//            Optional abort port: define LPM_RAM_BURST_READER_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lpm_ram_burst_reader #(
    parameter        lpm_type     = "lpm_ram_burst_reader",
    parameter int    lpm_width    = 1,
    parameter int    lpm_widthad  = 1,
    parameter int    lpm_numwords = 1 << lpm_widthad,
    parameter int    rd_latency   = 2
) (
    input  logic                   clock,
    input  logic                   aclr,
    input  logic                   start,
`ifdef LPM_RAM_BURST_READER_ABORT_EN
    input  logic                   abort,
`endif
    input  logic [lpm_widthad-1:0] base_addr,
    input  logic [lpm_widthad:0]   length,
    output logic                   busy,
    output logic                   done,
    output logic [lpm_widthad-1:0] rdaddress,
    output logic                   rden,
    input  logic [lpm_width-1:0]   ram_q,
    output logic [lpm_width-1:0]   q,
    output logic                   q_valid,
    input  logic                   q_ready
);

    localparam int c_depth = rd_latency + 2;
    localparam int c_cnt_w = $clog2(c_depth + 1);
    localparam int c_ptr_w = $clog2(c_depth);
    localparam int c_sum_w = c_cnt_w + 1;
    localparam logic [lpm_widthad-1:0] c_last_addr = lpm_widthad'(lpm_numwords - 1);
    localparam logic [c_ptr_w-1:0]     c_last_ptr  = c_ptr_w'(c_depth - 1);
    localparam logic [c_sum_w-1:0]     c_credits   = c_sum_w'(c_depth);

    generate
        if (rd_latency < 1 || rd_latency > 2 || lpm_numwords < 1 ||
            lpm_numwords > (1 << lpm_widthad) ||
            lpm_type != "lpm_ram_burst_reader") begin : g_param_check
            $error("lpm_ram_burst_reader: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [lpm_widthad-1:0] r_addr;
    logic [lpm_widthad-1:0] r_last_addr;
    logic [lpm_widthad:0]   r_remain;
    logic                   r_zero_done;
    logic [rd_latency:1]    r_rd_pipe;
    logic [c_cnt_w-1:0]     r_inflight;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [lpm_width-1:0]   r_mem [c_depth];

    logic                   w_abort_req;
    logic                   w_q_valid;
    logic                   w_pop;
    logic                   w_tap;
    logic [c_sum_w-1:0]     w_occ_sum;
    logic                   w_room;
    logic                   w_drain_done;
    logic                   w_abort_done;
    logic                   w_done_now;
    logic                   w_busy;
    logic                   w_abort_now;
    logic                   w_issue;
    logic                   w_discard;
    logic                   w_push;
    logic                   w_accept;
    logic                   w_len_zero;

`ifdef LPM_RAM_BURST_READER_ABORT_EN
    assign w_abort_req = abort;
`else
    assign w_abort_req = 1'b0;
`endif

    // Credit check counts words already buffered plus reads still in the RAM
    // pipe, so every issued read is guaranteed a FIFO slot when it lands.
    assign w_q_valid    = (r_count != '0);
    assign w_pop        = w_q_valid & q_ready;
    assign w_tap        = r_rd_pipe[rd_latency];
    assign w_occ_sum    = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_room       = (w_occ_sum < c_credits);
    assign w_drain_done = (r_state == S_DRAIN) && (r_inflight == '0) && !w_q_valid;
    assign w_abort_done = (r_state == S_ABORT) && (r_inflight == '0);
    assign w_done_now   = w_drain_done | w_abort_done;
    assign w_busy       = (r_state != S_IDLE) && !w_done_now;
    assign w_abort_now  = w_abort_req && w_busy && (r_state != S_ABORT);
    assign w_issue      = (r_state == S_ISSUE) && w_room && !w_abort_now;
    assign w_discard    = w_abort_now || (r_state == S_ABORT);
    assign w_push       = w_tap && !w_discard;
    assign w_accept     = start && ((r_state == S_IDLE) || w_done_now);
    assign w_len_zero   = (length == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_len_zero) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_abort_now) begin
                    w_state_nxt = S_ABORT;
                end else if (w_issue && (r_remain == (lpm_widthad+1)'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN, S_ABORT: begin
                if (w_abort_now) begin
                    w_state_nxt = S_ABORT;
                end else if (w_done_now) begin
                    w_state_nxt = (w_accept && !w_len_zero) ? S_ISSUE : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_addr      <= '0;
            r_last_addr <= '0;
            r_remain    <= '0;
            r_zero_done <= 1'b0;
            r_rd_pipe   <= '0;
            r_inflight  <= '0;
        end else begin
            r_zero_done <= w_accept && w_len_zero;
            if (w_accept && !w_len_zero) begin
                r_addr   <= base_addr;
                r_remain <= length;
            end else if (w_issue) begin
                r_addr      <= (r_addr == c_last_addr) ? '0 : r_addr + 1'b1;
                r_remain    <= r_remain - 1'b1;
                r_last_addr <= r_addr;
            end
            r_rd_pipe[1] <= w_issue;
            for (int k = 2; k <= rd_latency; k++) begin
                r_rd_pipe[k] <= r_rd_pipe[k-1];
            end
            r_inflight <= r_inflight + c_cnt_w'(w_issue) - c_cnt_w'(w_tap);
        end
    end

    // FIFO bookkeeping; an abort flushes the buffered words in one cycle.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_abort_now) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ram_q;
        end
    end

    assign busy      = w_busy;
    assign done      = w_done_now | r_zero_done;
    assign rden      = w_issue;
    assign rdaddress = w_issue ? r_addr : r_last_addr;
    assign q_valid   = w_q_valid;
    assign q         = w_q_valid ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: doc/lpm_ram_burst_reader.md
# lpm_ram_burst_reader

- Burst read initiator for the read port of a dual-port LPM RAM: drives `rdaddress`/`rden` and collects `ram_q` after a fixed read latency.
- Returns the words on a valid/ready stream.
- Credit-limited skid FIFO absorbs in-flight reads, so downstream backpressure never loses data.
- Sits between a RAM's read port (`rdclock` tied to `clock`, `rdclken` tied high) and any streaming consumer.

## Interface
- `lpm_type`, "lpm_ram_burst_reader", type tag
- `lpm_width`, 1, data word width
- `lpm_widthad`, 1, address width
- `lpm_numwords`, 1<<lpm_widthad, RAM depth; addresses wrap at this value
- `rd_latency`, 2, cycles from `rden` issue to valid `ram_q` (1 or 2)

Ports:
- `clock` in 1: single clock
- `aclr` in 1: reset, asynchronous, active-high
- `start` in 1: begin burst; ignored while `busy`
- `base_addr` in lpm_widthad: first address, latched on `start`
- `length` in lpm_widthad+1: word count, 0..lpm_numwords, latched on `start`
- `busy` out 1: burst in progress
- `done` out 1: one-cycle completion pulse
- `rdaddress` out lpm_widthad: RAM read address
- `rden` out 1: RAM read enable
- `ram_q` in lpm_width: RAM read data
- `q` out lpm_width: stream data
- `q_valid` out 1: `q` holds a word
- `q_ready` in 1: consumer accepts the word

## Operation
- FIFO depth D = rd_latency+2.
- Latency shift register of `rden`: when its tap at rd_latency is 1, `ram_q` is written to the FIFO that cycle.
- `inflight` = number of issued reads not yet written.

State machine: IDLE, ISSUE, DRAIN.
- **IDLE**
  - `start` with length>0: latch addr=base_addr, remain=length, go to ISSUE.
  - `start` with length==0: `done` pulses next cycle, stay IDLE.
- **ISSUE**
  - A read is issued in a cycle when occupancy+inflight < D (current-cycle pop not counted).
  - On issue: `rden`=1, `rdaddress`=addr. addr increments, and addr==lpm_numwords-1 wraps to 0. remain decrements.
  - When the last word is issued, go to DRAIN.
- **DRAIN**
  - Leave when inflight==0, FIFO empty and the final word has been accepted.
  - `done`=1 for that one cycle, then return to IDLE.

Stream rules:
- `q_valid` = FIFO non-empty.
- `q` is the FIFO head and stays stable while `q_valid` && !`q_ready`.
- A word transfers when `q_valid` && `q_ready`.
- Words are delivered in address order.
- Simultaneous FIFO write and pop is allowed at any occupancy, including full.
- Overflow is impossible by construction.
- `rden`=0 whenever no issue occurs; `rdaddress` holds its last value.
- `start` while busy is ignored; latched values are unchanged.

## Timing
- Reset values while `aclr`=1: `busy`, `done`, `rden`, `q_valid`=0; `rdaddress`=0; `q`=0. FSM in IDLE, FIFO and latency pipe empty.
- `aclr` mid-burst: everything is discarded immediately and no `done` is produced.
- With `start` in cycle 0: `busy`=1 from cycle 1, first `rden` in cycle 1.
- First `ram_q` sample at the end of cycle 1+rd_latency; first `q_valid` in cycle 2+rd_latency (cycle 4 at the default).
- Throughput is one word per cycle with `q_ready` held high.
- `done` and `busy`=0 occur in the cycle after the last transfer.
- A new `start` is accepted in the `done` cycle.

## Configuration
- **`LPM_RAM_BURST_READER_ABORT_EN` defined:** adds input port `abort`.
  - `abort`=1 while busy: stop issuing, flush the FIFO, drop `q_valid` next cycle, and discard data arriving from inflight reads.
  - After that, `done` pulses in the cycle after inflight reaches 0.
  - `abort` in IDLE has no effect.
- **Macro undefined:** the port is absent; every burst runs to completion.

## Test plan
- base_addr=5, length=4, `q_ready`=1, RAM[i]=i+0x10, rd_latency=2 -> `rden` in cycles 1–4, `q`=0x15,0x16,0x17,0x18 in cycles 4–7, `done` in cycle 8.
- lpm_widthad=3, base_addr=6, length=4 -> `rdaddress` sequence 6,7,0,1.
- length=4, `q_ready`=0 until cycle 12 -> at most 4 `rden` pulses, `q`=first word held stable, all 4 words delivered in order after release.
- length=0 -> `done` in cycle 1, no `rden`, `busy` stays 0. A second `start` during a burst is ignored.
- `aclr` asserted in cycle 3 of a length=8 burst -> all outputs 0 at once, no `done`. A fresh burst after release runs correctly.
- ABORT_EN: `abort` in cycle 3 of a length=8 burst -> `rden` stops, `q_valid`=0 next cycle, `done` once inflight drains.
